// File: rtl/arvi_bus_pkg.sv
// ---------------------------------------------------------------------------
// arvi_bus_pkg
// Shared definitions for the ARVI bus arbiter:
//   - arb_state_e    : arbiter FSM state encoding (IDLE / GRANT)
//   - ARVI_IDX_W     : width of a master index (up to 8 masters)
//   - ARVI_ERR_DATA  : all-ones read data returned on a watchdog timeout
//   - onehot_to_idx  : one-hot grant vector -> binary master index
// ---------------------------------------------------------------------------
package arvi_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int ARVI_MAX_MASTERS = 8;
  localparam int ARVI_IDX_W       = 3;
  localparam int ARVI_MAX_DATA_W  = 1024;

  // Sliced down to DATA_W by the user.
  localparam logic [ARVI_MAX_DATA_W-1:0] ARVI_ERR_DATA = '1;

  // OR-reduction of the set bit positions; exact for a one-hot (or zero) input.
  function automatic logic [ARVI_IDX_W-1:0] onehot_to_idx(
    input logic [ARVI_MAX_MASTERS-1:0] oh
  );
    logic [ARVI_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARVI_MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | ARVI_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arvi_bus_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arvi_arb_pick
// Combinational request picker. Scans the request vector starting at i_ptr
// and wrapping around; the first requester found is granted (one-hot).
// With i_ptr tied to 0 this degenerates to fixed lowest-index priority.
// Ports:
//   i_req  [N_MASTERS]  : request vector
//   i_ptr  [ARVI_IDX_W] : index where the search starts (must be < N_MASTERS)
//   o_gnt  [N_MASTERS]  : one-hot grant, all zero when nothing requests
// ---------------------------------------------------------------------------
module arvi_arb_pick
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]  i_req,
  input  logic [ARVI_IDX_W-1:0] i_ptr,
  output logic [N_MASTERS-1:0]  o_gnt
);

  localparam int IW = $clog2(N_MASTERS);

  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      sel = IW'((int'(i_ptr) + i) % N_MASTERS);
      if (!found && i_req[sel]) begin
        o_gnt[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arvi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// arvi_bus_arbiter
// Arbitrates N_MASTERS bus masters onto a single slave port. One transaction
// is in flight at a time: IDLE picks a requester (1-cycle latency), GRANT
// passes the owner's request fields straight through to the slave until the
// slave acks, the owner aborts (drops bus_en) or the watchdog expires.
//
// Build option:
//   ARVI_ARB_ROUND_ROBIN_EN defined   : round-robin, pointer advances past the
//                                       owner on every completion
//   ARVI_ARB_ROUND_ROBIN_EN undefined : fixed priority, lowest index wins
//
// Ports:
//   i_clk, i_rstn (async, active-low)
//   i_m_bus_en/i_m_wr_en [N]       : per-master request / write strobe
//   i_m_addr/i_m_wr_data/i_m_byte_en : packed per-master fields (master k at slice k)
//   o_m_ack [N], o_m_rd_data         : per-master ack pulse, shared read data
//   o_s_*                             : request toward the slave
//   i_s_ack, i_s_rd_data              : slave response
//   o_grant [N]                       : one-hot current owner
//   o_timeout                         : one-cycle watchdog error pulse
// ---------------------------------------------------------------------------
module arvi_bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [N_MASTERS-1:0]          i_m_bus_en,
  input  logic [N_MASTERS-1:0]          i_m_wr_en,
  input  logic [N_MASTERS*ADDR_W-1:0]   i_m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   i_m_wr_data,
  input  logic [N_MASTERS*DATA_W/8-1:0] i_m_byte_en,
  output logic [N_MASTERS-1:0]          o_m_ack,
  output logic [DATA_W-1:0]             o_m_rd_data,
  output logic                          o_s_bus_en,
  output logic                          o_s_wr_en,
  output logic [ADDR_W-1:0]             o_s_addr,
  output logic [DATA_W-1:0]             o_s_wr_data,
  output logic [DATA_W/8-1:0]           o_s_byte_en,
  input  logic                          i_s_ack,
  input  logic [DATA_W-1:0]             i_s_rd_data,
  output logic [N_MASTERS-1:0]          o_grant,
  output logic                          o_timeout
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = $clog2(N_MASTERS);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic [N_MASTERS-1:0]   pick_gnt;
  logic [ARVI_IDX_W-1:0]  ptr;
  logic [IW-1:0]          gidx;
  logic                   g_bus_en;
  logic                   complete;

  assign gidx     = IW'(onehot_to_idx(ARVI_MAX_MASTERS'(grant_q)));
  assign g_bus_en = i_m_bus_en[gidx];
  assign o_grant  = grant_q;

`ifdef ARVI_ARB_ROUND_ROBIN_EN
  logic [ARVI_IDX_W-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  // Advance past the owner whenever its transaction ends, however it ends.
  always_comb begin
    ptr_d = ptr_q;
    if (complete) begin
      ptr_d = (int'(gidx) == N_MASTERS - 1) ? '0 : ARVI_IDX_W'(int'(gidx) + 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  arvi_arb_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .i_req (i_m_bus_en),
    .i_ptr (ptr),
    .o_gnt (pick_gnt)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    complete    = 1'b0;
    o_s_bus_en  = 1'b0;
    o_s_wr_en   = 1'b0;
    o_s_addr    = '0;
    o_s_wr_data = '0;
    o_s_byte_en = '0;
    o_m_ack     = '0;
    o_m_rd_data = '0;
    o_timeout   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A slave ack seen here is stray and is dropped on purpose.
        if (|i_m_bus_en) begin
          grant_d = pick_gnt;
          wdog_d  = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        o_s_bus_en  = g_bus_en;
        o_s_wr_en   = i_m_wr_en[gidx];
        o_s_addr    = i_m_addr[int'(gidx)*ADDR_W +: ADDR_W];
        o_s_wr_data = i_m_wr_data[int'(gidx)*DATA_W +: DATA_W];
        o_s_byte_en = i_m_byte_en[int'(gidx)*BE_W +: BE_W];

        if (!g_bus_en) begin
          // Owner withdrew: release silently.
          complete = 1'b1;
        end else if (i_s_ack) begin
          // Slave ack takes precedence over a watchdog expiring this cycle.
          o_m_ack     = grant_q;
          o_m_rd_data = i_s_rd_data;
          complete    = 1'b1;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th GRANT cycle without an ack.
          o_m_ack     = grant_q;
          o_m_rd_data = ARVI_ERR_DATA[DATA_W-1:0];
          o_timeout   = 1'b1;
          complete    = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end

        if (complete) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_arvi_bus_arbiter.sv
module tb_arvi_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     m_bus_en, m_wr_en;
  logic [N*AW-1:0]  m_addr;
  logic [N*DW-1:0]  m_wr_data;
  logic [N*DW/8-1:0] m_byte_en;
  logic [N-1:0]     m_ack;
  logic [DW-1:0]    m_rd_data;
  logic             s_bus_en, s_wr_en;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wr_data;
  logic [DW/8-1:0]  s_byte_en;
  logic             s_ack;
  logic [DW-1:0]    s_rd_data;
  logic [N-1:0]     grant;
  logic             timeout;

  arvi_bus_arbiter #(
    .N_MASTERS (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_m_bus_en  (m_bus_en),
    .i_m_wr_en   (m_wr_en),
    .i_m_addr    (m_addr),
    .i_m_wr_data (m_wr_data),
    .i_m_byte_en (m_byte_en),
    .o_m_ack     (m_ack),
    .o_m_rd_data (m_rd_data),
    .o_s_bus_en  (s_bus_en),
    .o_s_wr_en   (s_wr_en),
    .o_s_addr    (s_addr),
    .o_s_wr_data (s_wr_data),
    .o_s_byte_en (s_byte_en),
    .i_s_ack     (s_ack),
    .i_s_rd_data (s_rd_data),
    .o_grant     (grant),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bus_en;
    logic        ack_in;
    logic [31:0] rd_in;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_sbus;
    logic [31:0] e_rd;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h required %h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic add(input logic [3:0] be, input logic a, input logic [31:0] rd,
                     input logic [3:0] eg, input logic [3:0] ea, input logic es,
                     input logic [31:0] er, input logic et);
    vec_t v;
    v.bus_en = be; v.ack_in = a; v.rd_in = rd;
    v.e_grant = eg; v.e_ack = ea; v.e_sbus = es; v.e_rd = er; v.e_to = et;
    vecs.push_back(v);
  endtask

  // Each master k sits at address k*0x100.
  function automatic logic [31:0] addr_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return 32'h000;
      4'b0010: return 32'h100;
      4'b0100: return 32'h200;
      4'b1000: return 32'h300;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, 32'(grant), 32'h0);
    chk({nm, "_ack"}, 32'(m_ack), 32'h0);
    chk({nm, "_sbus"}, 32'(s_bus_en), 32'h0);
    chk({nm, "_saddr"}, s_addr, 32'h0);
    chk({nm, "_rd"}, m_rd_data, 32'h0);
    chk({nm, "_to"}, 32'(timeout), 32'h0);
  endtask

  initial begin
    logic [3:0] g;
    rst_n = 1'b0;
    m_bus_en = '0; m_wr_en = '0; s_ack = 1'b0; s_rd_data = '0;
    for (int k = 0; k < N; k++) begin
      m_addr[k*AW +: AW]      = 32'(k) * 32'h100;
      m_wr_data[k*DW +: DW]   = (k == 1) ? 32'hCAFEF00D : 32'hD000_0000 + 32'(k);
      m_byte_en[k*4 +: 4]     = (k == 1) ? 4'hF : 4'h3;
    end

    // Contention: all request, slave acks every cycle (ack in IDLE ignored).
    for (int k = 0; k < 5; k++) begin
`ifdef ARVI_ARB_ROUND_ROBIN_EN
      g = 4'(1 << (k % 4));
`else
      g = 4'h1;
`endif
      add(4'hF, 1'b1, 32'h12345678, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
      add(4'hF, 1'b1, 32'h12345678, g, g, 1'b1, 32'h12345678, 1'b0);
    end
    add(4'h0, 1'b1, 32'hDEADBEEF, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    // Watchdog expiry on master 2, then pending master 3 served.
    add(4'hC, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) add(4'hC, 1'b0, 32'h0, 4'h4, 4'h0, 1'b1, 32'h0, 1'b0);
    add(4'hC, 1'b0, 32'h0, 4'h4, 4'h4, 1'b1, 32'hFFFFFFFF, 1'b1);
    add(4'h8, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    add(4'h8, 1'b1, 32'hA5A50003, 4'h8, 4'h8, 1'b1, 32'hA5A50003, 1'b0);
    add(4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    // Ack lands on the would-be timeout cycle: ack wins.
    add(4'h1, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) add(4'h1, 1'b0, 32'h0, 4'h1, 4'h0, 1'b1, 32'h0, 1'b0);
    add(4'h1, 1'b1, 32'h0BADF00D, 4'h1, 4'h1, 1'b1, 32'h0BADF00D, 1'b0);
    add(4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    // Abort by master 1 on its 2nd GRANT cycle; master 2 served next.
    add(4'h6, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    add(4'h6, 1'b0, 32'h0, 4'h2, 4'h0, 1'b1, 32'h0, 1'b0);
    add(4'h4, 1'b0, 32'h0, 4'h2, 4'h0, 1'b0, 32'h0, 1'b0);
    add(4'h4, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    add(4'h4, 1'b1, 32'h55AA55AA, 4'h4, 4'h4, 1'b1, 32'h55AA55AA, 1'b0);
    add(4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    // Reset state.
    @(negedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      m_bus_en = vecs[i].bus_en; s_ack = vecs[i].ack_in; s_rd_data = vecs[i].rd_in;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_ack", i), 32'(m_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_sbus", i), 32'(s_bus_en), 32'(vecs[i].e_sbus));
      chk($sformatf("v%0d_rd", i), m_rd_data, vecs[i].e_rd);
      chk($sformatf("v%0d_to", i), 32'(timeout), 32'(vecs[i].e_to));
      chk($sformatf("v%0d_saddr", i), s_addr, addr_of(vecs[i].e_grant));
    end

    // Single write from master 1, slave acks on the 3rd cycle.
    @(negedge clk);
    m_bus_en = 4'h2; m_wr_en = 4'h2; s_ack = 1'b0; s_rd_data = '0;
    #1;
    chk("wr_c1_grant", 32'(grant), 32'h0);
    chk("wr_c1_sbus", 32'(s_bus_en), 32'h0);
    @(negedge clk); #1;
    chk("wr_c2_grant", 32'(grant), 32'h2);
    chk("wr_c2_sbus", 32'(s_bus_en), 32'h1);
    chk("wr_c2_swr", 32'(s_wr_en), 32'h1);
    chk("wr_c2_saddr", s_addr, 32'h100);
    chk("wr_c2_sdata", s_wr_data, 32'hCAFEF00D);
    chk("wr_c2_sbe", 32'(s_byte_en), 32'hF);
    chk("wr_c2_ack", 32'(m_ack), 32'h0);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("wr_c3_ack", 32'(m_ack), 32'h2);
    chk("wr_c3_to", 32'(timeout), 32'h0);
    @(negedge clk);
    m_bus_en = 4'h0; m_wr_en = 4'h0; s_ack = 1'b0;
    #1;
    chk("wr_c4_grant", 32'(grant), 32'h0);
    chk("wr_c4_ack", 32'(m_ack), 32'h0);

    // Reset asserted mid-GRANT, then a fresh request from masters 0 and 2.
    @(negedge clk);
    m_bus_en = 4'h5;
    #1;
    chk("rst_c1_grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
`ifdef ARVI_ARB_ROUND_ROBIN_EN
    chk("rst_c2_grant", 32'(grant), 32'h4);
`else
    chk("rst_c2_grant", 32'(grant), 32'h1);
`endif
    #2;
    s_ack = 1'b1; s_rd_data = 32'h77777777;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk); #1;
    chk_zero("rst_held");
    s_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    s_ack = 1'b1; s_rd_data = 32'h600D0000;
    #1;
    chk("post_grant", 32'(grant), 32'h1);
    chk("post_saddr", s_addr, 32'h0);
    chk("post_ack", 32'(m_ack), 32'h1);
    chk("post_rd", m_rd_data, 32'h600D0000);
    @(negedge clk);
    m_bus_en = 4'h0; s_ack = 1'b0;
    #1;
    chk("post_end_grant", 32'(grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arvi_bus_arbiter.md
ARVI_BUS_ARBITER -- requirements
Module: arvi_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of bus masters (range 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, data width (byte_en width DATA_W/8).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles waiting for slave ack (must be >=1).
REQ-005 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 i_rstn  in  1  reset, asynchronous, active-low.
REQ-007 i_m_bus_en, i_m_wr_en  in  N_MASTERS each  per-master request and write strobe.
REQ-008 i_m_addr  in  N_MASTERS*ADDR_W; i_m_wr_data  in  N_MASTERS*DATA_W; i_m_byte_en  in  N_MASTERS*DATA_W/8; packed, master k at slice k.
REQ-009 o_m_ack  out  N_MASTERS; o_m_rd_data  out  DATA_W (shared, valid only with ack).
REQ-010 o_s_bus_en, o_s_wr_en  out  1; o_s_addr  out  ADDR_W; o_s_wr_data  out  DATA_W; o_s_byte_en  out  DATA_W/8; master-side port to slave.
REQ-011 i_s_ack  in  1; i_s_rd_data  in  DATA_W; slave response.
REQ-012 o_grant  out  N_MASTERS one-hot current owner; o_timeout  out  1 one-cycle error pulse.

Function
REQ-013 Bus protocol: master holds bus_en and all request fields stable until it sees ack (one-cycle pulse); it drops bus_en the cycle after ack.
REQ-014 FSM states IDLE, GRANT; reset state IDLE.
REQ-015 IDLE: o_s_bus_en=0, o_grant=0; if any i_m_bus_en set, select one master, register grant, go GRANT next cycle (1 cycle arbitration latency).
REQ-016 GRANT: o_s_* fields combinationally mux the granted master's inputs; o_s_bus_en = granted master's i_m_bus_en.
REQ-017 GRANT: on i_s_ack=1, o_m_ack[granted]=1 same cycle, o_m_rd_data=i_s_rd_data, FSM returns IDLE; no re-arbitration in that cycle.
REQ-018 Non-granted masters SHALL never see ack; their requests stay pending without loss.
REQ-019 Granted master dropping bus_en in GRANT without ack (abort): FSM returns IDLE next cycle, no ack issued.
REQ-020 Watchdog counter cleared on entry to GRANT, increments each GRANT cycle without ack; on reaching TIMEOUT: o_m_ack[granted]=1, o_m_rd_data=all-ones, o_timeout=1 for one cycle, return IDLE.
REQ-021 Ack and timeout in the same cycle: slave ack wins, o_timeout=0.
REQ-022 i_s_ack while IDLE SHALL be ignored.
REQ-023 o_m_rd_data SHALL be 0 when no ack is asserted.

Reset
REQ-024 Asynchronous assertion of i_rstn low: FSM IDLE, grant 0, watchdog 0, priority pointer 0, all outputs 0, within the same cycle.
REQ-025 Reset mid-transaction drops the transaction silently; no ack emitted; deassertion takes effect at next rising edge.

Configuration
REQ-026 Macro ARVI_ARB_ROUND_ROBIN_EN defined: round-robin; pointer moves to (granted+1) mod N_MASTERS on each completion (ack, timeout or abort); search starts at pointer.
REQ-027 Macro undefined: fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-028 Shared package arvi_bus_pkg holds FSM state enum, all-ones error data constant, and onehot/index conversion function.
REQ-029 One sub-module arvi_arb_pick: combinational request vector + start pointer -> one-hot grant; used in both modes (pointer tied 0 in fixed mode).

Verification
REQ-030 Single request: master 1 writes addr 0x100, data 0xCAFEF00D, byte_en 0xF; slave acks cycle 3 -> o_s_* match, o_m_ack[1] pulses once, grant cleared next cycle.
REQ-031 Contention N=4, masters 0..3 request continuously, 1-cycle slave ack: RR -> grant order 0,1,2,3,0; fixed -> master 0 only, others stall.
REQ-032 Read: slave returns 0x12345678 with ack -> only granted master acked, o_m_rd_data=0x12345678 that cycle, 0 otherwise.
REQ-033 TIMEOUT=4, slave never acks -> o_timeout and ack on 4th GRANT cycle, rd_data=0xFFFFFFFF, next request granted.
REQ-034 Abort: granted master drops bus_en cycle 2 -> IDLE, no ack; pending master granted next.
REQ-035 i_rstn low mid-GRANT -> all outputs 0 immediately; post-reset request served normally from master 0.
